// File: rtl/mac_lane_scheduler.sv
// Round-robin dispatch of TLAST-delimited dot-product packets over C_NUM_MACS lanes; results return in dispatch order tagged by TID.
// Zero-latency dispatch and collect paths; input stalls while the target lane is busy or not ready, results wait on M_AXIS_TREADY.
module mac_lane_scheduler #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_NUM_MACS   = 4
) (
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    input  logic [2*C_DATA_WIDTH-1:0]             S_AXIS_TDATA,
    input  logic                                  S_AXIS_TVALID,
    output logic                                  S_AXIS_TREADY,
    input  logic                                  S_AXIS_TLAST,
    input  logic [7:0]                            S_AXIS_TID,
    output logic [C_NUM_MACS*2*C_DATA_WIDTH-1:0]  LANE_TDATA,
    output logic [C_NUM_MACS-1:0]                 LANE_TVALID,
    output logic [C_NUM_MACS-1:0]                 LANE_TLAST,
    input  logic [C_NUM_MACS-1:0]                 LANE_TREADY,
    input  logic [C_NUM_MACS*32-1:0]              RES_TDATA,
    input  logic [C_NUM_MACS-1:0]                 RES_TVALID,
    output logic [C_NUM_MACS-1:0]                 RES_TREADY,
    output logic [31:0]                           M_AXIS_TDATA,
    output logic                                  M_AXIS_TVALID,
    input  logic                                  M_AXIS_TREADY,
    output logic                                  M_AXIS_TLAST,
    output logic [7:0]                            M_AXIS_TID,
    output logic [C_NUM_MACS-1:0]                 LANE_BUSY,
    output logic [$clog2(C_NUM_MACS):0]           IN_FLIGHT
);
    localparam int LW = $clog2(C_NUM_MACS);

    logic [LW-1:0]         disp_lane_q, disp_lane_d;
    logic [C_NUM_MACS-1:0] busy_q, busy_d;
    logic [C_NUM_MACS-1:0] mid_q, mid_d;
    logic [LW-1:0]         fifo_lane_q [C_NUM_MACS];
    logic [LW-1:0]         fifo_lane_d [C_NUM_MACS];
    logic [7:0]            fifo_tid_q  [C_NUM_MACS];
    logic [7:0]            fifo_tid_d  [C_NUM_MACS];
    logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW:0]           count_q, count_d;

    logic [LW-1:0] head_lane;
    logic [7:0]    head_tid;
    logic          fifo_nempty;
    logic          s_rdy;
    logic          beat_acc;
    logic          push;
    logic          m_vld;
    logic          pop;

    always_comb begin
        head_lane   = fifo_lane_q[rd_ptr_q];
        head_tid    = fifo_tid_q[rd_ptr_q];
        fifo_nempty = (count_q != '0);
        s_rdy       = !busy_q[disp_lane_q] && LANE_TREADY[disp_lane_q];
        beat_acc    = S_AXIS_TVALID && s_rdy;
        push        = beat_acc && S_AXIS_TLAST;
        m_vld       = fifo_nempty && RES_TVALID[head_lane];
        pop         = m_vld && M_AXIS_TREADY;
    end

    // Only the dispatch lane sees valid; only the head lane of the order FIFO may hand over its result.
    always_comb begin
        LANE_TDATA   = {C_NUM_MACS{S_AXIS_TDATA}};
        LANE_TVALID  = '0;
        LANE_TLAST   = '0;
        RES_TREADY   = '0;
        M_AXIS_TDATA = '0;
        for (int k = 0; k < C_NUM_MACS; k++) begin
            if (disp_lane_q == LW'(k)) begin
                LANE_TVALID[k] = S_AXIS_TVALID && !busy_q[k];
                LANE_TLAST[k]  = S_AXIS_TLAST;
            end
            if (head_lane == LW'(k)) begin
                RES_TREADY[k] = M_AXIS_TREADY && fifo_nempty;
                M_AXIS_TDATA  = RES_TDATA[k*32 +: 32];
            end
        end
    end

    assign S_AXIS_TREADY = s_rdy;
    assign M_AXIS_TVALID = m_vld;
    assign M_AXIS_TLAST  = m_vld;
    assign M_AXIS_TID    = head_tid;
    assign LANE_BUSY     = busy_q;
    assign IN_FLIGHT     = count_q;

    always_comb begin
        disp_lane_d = disp_lane_q;
        busy_d      = busy_q;
        mid_d       = mid_q;
        fifo_lane_d = fifo_lane_q;
        fifo_tid_d  = fifo_tid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (beat_acc) begin
            mid_d[disp_lane_q] = !S_AXIS_TLAST;
        end
        // A push targets a free lane and a pop a busy one, so the two never touch the same busy bit.
        if (push) begin
            busy_d[disp_lane_q]   = 1'b1;
            fifo_lane_d[wr_ptr_q] = disp_lane_q;
            fifo_tid_d[wr_ptr_q]  = S_AXIS_TID;
            wr_ptr_d              = wr_ptr_q + LW'(1);
            disp_lane_d           = disp_lane_q + LW'(1);
        end
        if (pop) begin
            busy_d[head_lane] = 1'b0;
            rd_ptr_d          = rd_ptr_q + LW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (LW+1)'(1);
            2'b01:   count_d = count_q - (LW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            disp_lane_q <= '0;
            busy_q      <= '0;
            mid_q       <= '0;
            fifo_lane_q <= '{default: '0};
            fifo_tid_q  <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            disp_lane_q <= disp_lane_d;
            busy_q      <= busy_d;
            mid_q       <= mid_d;
            fifo_lane_q <= fifo_lane_d;
            fifo_tid_q  <= fifo_tid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_mac_lane_scheduler.sv
// Bench for mac_lane_scheduler: packet-queue model of dispatch/retire plus responder MAC lanes with per-lane result delay.
module tb_mac_lane_scheduler;
    localparam int DW = 8;
    localparam int N  = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [2*DW-1:0]   S_AXIS_TDATA;
    logic              S_AXIS_TVALID;
    logic              S_AXIS_TREADY;
    logic              S_AXIS_TLAST;
    logic [7:0]        S_AXIS_TID;
    logic [N*2*DW-1:0] LANE_TDATA;
    logic [N-1:0]      LANE_TVALID;
    logic [N-1:0]      LANE_TLAST;
    logic [N-1:0]      LANE_TREADY;
    logic [N*32-1:0]   RES_TDATA;
    logic [N-1:0]      RES_TVALID;
    logic [N-1:0]      RES_TREADY;
    logic [31:0]       M_AXIS_TDATA;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TREADY;
    logic              M_AXIS_TLAST;
    logic [7:0]        M_AXIS_TID;
    logic [N-1:0]      LANE_BUSY;
    logic [$clog2(N):0] IN_FLIGHT;

    always #5 ACLK = ~ACLK;

    mac_lane_scheduler #(.C_DATA_WIDTH(DW), .C_NUM_MACS(N)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TID(S_AXIS_TID),
        .LANE_TDATA(LANE_TDATA), .LANE_TVALID(LANE_TVALID), .LANE_TLAST(LANE_TLAST), .LANE_TREADY(LANE_TREADY),
        .RES_TDATA(RES_TDATA), .RES_TVALID(RES_TVALID), .RES_TREADY(RES_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TID(M_AXIS_TID),
        .LANE_BUSY(LANE_BUSY), .IN_FLIGHT(IN_FLIGHT)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur within its bound", nm);
    endtask

    // Model: packets in flight, oldest first, with the sum each must produce.
    typedef struct {
        int lane;
        int tid;
        int sum;
    } pkt_t;

    pkt_t q[$];
    int   disp_m  = 0;
    int   cur_sum = 0;
    int   cyc     = 0;
    int   lane_log[$];
    int   out_dat[$];
    int   out_tid[$];
    int   disp_cyc[$];
    int   ret_cyc[$];

    int   lacc[N];
    int   lcnt[N];
    bit   lpend[N];
    int   ldelay[N];

    logic [N-1:0]    busy_m, exp_lv, exp_ll, exp_rr;
    logic [N-1:0]    beat_k, take_k, last_k;
    logic [2*DW-1:0] dat_k [N];
    logic            exp_rdy, exp_mv, rst_s;

    initial begin : monitor
        RES_TVALID = '0;
        RES_TDATA  = '0;
        for (int k = 0; k < N; k++) begin
            lacc[k]  = 0;
            lcnt[k]  = 0;
            lpend[k] = 1'b0;
        end
        forever begin
            @(negedge ACLK);
            busy_m = '0;
            foreach (q[i]) busy_m[q[i].lane] = 1'b1;
            exp_rdy = !busy_m[disp_m] && LANE_TREADY[disp_m];
            exp_lv  = '0;
            exp_ll  = '0;
            exp_rr  = '0;
            if (S_AXIS_TVALID && !busy_m[disp_m]) exp_lv[disp_m] = 1'b1;
            if (S_AXIS_TLAST) exp_ll[disp_m] = 1'b1;
            if (q.size() != 0 && M_AXIS_TREADY) exp_rr[q[0].lane] = 1'b1;
            exp_mv = (q.size() != 0) && RES_TVALID[q[0].lane];

            chk("in_flight", IN_FLIGHT, q.size());
            chk("lane_busy", LANE_BUSY, busy_m);
            chk("s_tready", S_AXIS_TREADY, exp_rdy);
            chk("lane_tvalid", LANE_TVALID, exp_lv);
            chk("lane_tlast", LANE_TLAST, exp_ll);
            chk("lane_tdata", LANE_TDATA, {N{S_AXIS_TDATA}});
            chk("m_tvalid", M_AXIS_TVALID, exp_mv);
            chk("res_tready", RES_TREADY, exp_rr);
            if (exp_mv) begin
                chk("m_tdata", M_AXIS_TDATA, q[0].sum);
                chk("m_tid", M_AXIS_TID, q[0].tid);
                chk("m_tlast", M_AXIS_TLAST, 1);
            end

            rst_s  = ARESET;
            beat_k = LANE_TVALID & LANE_TREADY;
            take_k = RES_TVALID & RES_TREADY;
            last_k = LANE_TLAST;
            for (int k = 0; k < N; k++) dat_k[k] = LANE_TDATA[k*2*DW +: 2*DW];

            if (rst_s) begin
                q.delete();
                disp_m  = 0;
                cur_sum = 0;
            end else begin
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    out_dat.push_back(int'(M_AXIS_TDATA));
                    out_tid.push_back(int'(M_AXIS_TID));
                    ret_cyc.push_back(cyc);
                    if (q.size() != 0) void'(q.pop_front());
                end
                if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                    cur_sum += int'(S_AXIS_TDATA[15:8]) * int'(S_AXIS_TDATA[7:0]);
                    for (int k = 0; k < N; k++) if (beat_k[k]) lane_log.push_back(k);
                    if (S_AXIS_TLAST) begin
                        q.push_back('{disp_m, int'(S_AXIS_TID), cur_sum});
                        disp_cyc.push_back(cyc);
                        cur_sum = 0;
                        disp_m  = (disp_m + 1) % N;
                    end
                end
            end
            cyc++;

            // MAC lanes respond to what crossed the edge just sampled.
            @(posedge ACLK);
            #1;
            for (int k = 0; k < N; k++) begin
                if (rst_s) begin
                    lacc[k]       = 0;
                    lpend[k]      = 1'b0;
                    RES_TVALID[k] = 1'b0;
                end else begin
                    if (take_k[k]) RES_TVALID[k] = 1'b0;
                    if (beat_k[k]) begin
                        lacc[k] += int'(dat_k[k][15:8]) * int'(dat_k[k][7:0]);
                        if (last_k[k]) begin
                            lpend[k] = 1'b1;
                            lcnt[k]  = ldelay[k];
                        end
                    end
                    if (lpend[k]) begin
                        if (lcnt[k] <= 1) begin
                            RES_TVALID[k]          = 1'b1;
                            RES_TDATA[k*32 +: 32]  = lacc[k];
                            lacc[k]                = 0;
                            lpend[k]               = 1'b0;
                        end else begin
                            lcnt[k]--;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input int a, input int b, input bit last, input int tid);
        S_AXIS_TDATA  = {8'(a), 8'(b)};
        S_AXIS_TLAST  = last;
        S_AXIS_TID    = 8'(tid);
        S_AXIS_TVALID = 1'b1;
    endtask

    task automatic wait_acc(output int stalls);
        stalls = 0;
        forever begin
            @(negedge ACLK);
            if (S_AXIS_TREADY) break;
            stalls++;
            if (stalls > 300) begin
                miss("s_accept_timeout");
                break;
            end
        end
        tick();
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic send(input int a, input int b, input bit last, input int tid);
        int st;
        drive(a, b, last, tid);
        wait_acc(st);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (out_dat.size() < n) begin
            tick();
            t++;
            if (t > 500) begin
                miss("result_timeout");
                break;
            end
        end
    endtask

    task automatic chk_out(input int i, input int d, input int t);
        if (out_dat.size() > i) begin
            chk($sformatf("out%0d_data", i), out_dat[i], d);
            chk($sformatf("out%0d_tid", i), out_tid[i], t);
        end else begin
            miss($sformatf("out%0d_present", i));
        end
    endtask

    task automatic chk_lane(input int i, input int l);
        if (lane_log.size() > i) chk($sformatf("beat%0d_lane", i), lane_log[i], l);
        else miss($sformatf("beat%0d_present", i));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d", cyc);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin : stim
        int st;
        ARESET        = 1'b1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TID    = '0;
        LANE_TREADY   = '1;
        M_AXIS_TREADY = 1'b0;
        ldelay        = '{1, 1, 1, 1};
        tick();
        tick();
        @(negedge ACLK);
        chk("rst_in_flight", IN_FLIGHT, 0);
        chk("rst_busy", LANE_BUSY, 0);
        chk("rst_m_tvalid", M_AXIS_TVALID, 0);
        chk("rst_res_tready", RES_TREADY, 0);
        chk("rst_lane_tvalid", LANE_TVALID, 0);
        chk("rst_s_tready", S_AXIS_TREADY, 1);
        tick();
        ARESET = 1'b0;

        // Four single-beat packets fill every lane.
        for (int i = 0; i < 4; i++) send(2, 3, 1'b1, 10 + i);
        @(negedge ACLK);
        chk("full_in_flight", IN_FLIGHT, 4);
        chk("full_busy", LANE_BUSY, 4'b1111);
        tick();

        drive(2, 3, 1'b1, 14);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("full_s_tready", S_AXIS_TREADY, 0);
            chk("full_busy_hold", LANE_BUSY, 4'b1111);
            tick();
        end
        M_AXIS_TREADY = 1'b1;
        wait_acc(st);
        wait_out(5);
        for (int i = 0; i < 4; i++) chk_out(i, 6, 10 + i);
        chk_out(4, 6, 14);
        for (int i = 0; i < 4; i++) chk_lane(i, i);
        chk_lane(4, 0);
        if (disp_cyc.size() > 4 && ret_cyc.size() > 0)
            chk("redispatch_cycle", disp_cyc[4], ret_cyc[0] + 1);
        else
            miss("redispatch_cycle");

        // Lane 2 finishes before lane 1 but must wait its turn.
        ldelay[1] = 6;
        send(1, 4, 1'b1, 8'h21);
        send(2, 5, 1'b1, 8'h22);
        @(negedge ACLK);
        chk("ooo_m_tvalid", M_AXIS_TVALID, 0);
        chk("ooo_res_tready", RES_TREADY, 4'b0010);
        tick();
        wait_out(7);
        chk_out(5, 4, 8'h21);
        chk_out(6, 10, 8'h22);
        chk_lane(5, 1);
        chk_lane(6, 2);
        ldelay[1] = 1;

        // Three-beat packet stays on lane 3.
        send(1, 1, 1'b0, 0);
        @(negedge ACLK);
        chk("mid_in_flight", IN_FLIGHT, 0);
        chk("mid_busy", LANE_BUSY, 0);
        tick();
        send(2, 2, 1'b0, 0);
        send(3, 3, 1'b1, 8'h55);
        wait_out(8);
        chk_out(7, 14, 8'h55);
        for (int i = 7; i < 10; i++) chk_lane(i, 3);

        // Lane 1 withholds ready for three cycles.
        send(3, 3, 1'b1, 8'h60);
        LANE_TREADY = 4'b1101;
        drive(4, 4, 1'b1, 8'h61);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("bp_s_tready", S_AXIS_TREADY, 0);
            tick();
        end
        LANE_TREADY = '1;
        wait_acc(st);
        chk("bp_extra_stall", st, 0);
        wait_out(10);
        chk_out(8, 9, 8'h60);
        chk_out(9, 16, 8'h61);
        chk_lane(10, 0);
        chk_lane(11, 1);

        // Reset with two packets in flight and a third mid-stream.
        M_AXIS_TREADY = 1'b0;
        send(6, 6, 1'b1, 8'h70);
        send(7, 7, 1'b1, 8'h71);
        send(1, 2, 1'b0, 0);
        @(negedge ACLK);
        chk("pre_rst_in_flight", IN_FLIGHT, 2);
        tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_in_flight", IN_FLIGHT, 0);
        chk("post_rst_busy", LANE_BUSY, 0);
        chk("post_rst_m_tvalid", M_AXIS_TVALID, 0);
        tick();
        M_AXIS_TREADY = 1'b1;
        repeat (5) tick();
        chk("post_rst_no_output", out_dat.size(), 10);
        send(5, 5, 1'b1, 8'h80);
        wait_out(11);
        chk_out(10, 25, 8'h80);
        chk_lane(15, 0);
        chk("total_lane_beats", lane_log.size(), 16);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_lane_scheduler.md
Name: mac_lane_scheduler

Overview:
- Shares one AXI-Stream source of packed (input, weight) pairs across C_NUM_MACS staged MAC lanes. Each TLAST-delimited packet is one dot product and goes whole to a single lane.
- Lanes are assigned round-robin. Lane results are returned on one 32-bit result stream in strict dispatch order, tagged with the packet's TID.
- Sits between the layer DMA stream and the MAC array. The scheduler carries TIDs itself because the MACs do not propagate them.

Parameters:
- C_DATA_WIDTH, 8, width of each of input and weight; a beat is 2*C_DATA_WIDTH bits.
- C_NUM_MACS, 4, number of MAC lanes; power of two, 2..16.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- S_AXIS_TDATA  in  2*C_DATA_WIDTH  {input, weight} beat
- S_AXIS_TVALID  in  1  beat valid
- S_AXIS_TREADY  out  1  beat accepted
- S_AXIS_TLAST  in  1  last beat of a dot product
- S_AXIS_TID  in  8  packet tag, sampled on the TLAST beat
- LANE_TDATA  out  C_NUM_MACS*2*C_DATA_WIDTH  per-lane beat; lane k occupies slice k
- LANE_TVALID  out  C_NUM_MACS  per-lane valid
- LANE_TLAST  out  C_NUM_MACS  per-lane last
- LANE_TREADY  in  C_NUM_MACS  per-lane ready
- RES_TDATA  in  C_NUM_MACS*32  per-lane result
- RES_TVALID  in  C_NUM_MACS  per-lane result valid
- RES_TREADY  out  C_NUM_MACS  per-lane result ready
- M_AXIS_TDATA  out  32  ordered result
- M_AXIS_TVALID  out  1  result valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TLAST  out  1  constant 1 whenever TVALID is high (one beat per result)
- M_AXIS_TID  out  8  tag of the result
- LANE_BUSY  out  C_NUM_MACS  lane holds an unretired packet
- IN_FLIGHT  out  $clog2(C_NUM_MACS)+1  packets dispatched but not yet retired

Behaviour:
- State:
  - disp_lane pointer.
  - busy[C_NUM_MACS] flags.
  - Order FIFO of {lane, TID}, depth C_NUM_MACS, with rd_ptr, wr_ptr and count.
  - Per-dispatch-lane "mid-packet" flag.
- Reset (ARESET=1 at a clock edge): disp_lane=0, busy=0, FIFO empty, IN_FLIGHT=0. Consequently S_AXIS_TREADY=0 only if LANE_TREADY[0]=0, and M_AXIS_TVALID=0, RES_TREADY=0, LANE_TVALID=0.
- Reset mid-operation discards all in-flight packets and tags; no output beat is produced for them. The MACs share the same reset.
- Dispatch path (combinational, zero latency):
  - LANE_TDATA slice k = S_AXIS_TDATA for every k.
  - LANE_TVALID[k] = S_AXIS_TVALID & (disp_lane==k) & !busy[k].
  - LANE_TLAST[k] = S_AXIS_TLAST & (disp_lane==k).
  - S_AXIS_TREADY = !busy[disp_lane] & LANE_TREADY[disp_lane].
- On an accepted TLAST beat:
  - busy[disp_lane] <= 1.
  - Push {disp_lane, S_AXIS_TID} to the FIFO.
  - disp_lane <= disp_lane+1, wrapping at C_NUM_MACS.
- Beats without TLAST do not move disp_lane; a packet never splits across lanes.
- FIFO cannot overflow: a push needs busy[disp_lane]=0, so count < C_NUM_MACS.
- Collect path (combinational):
  - head = FIFO[rd_ptr].
  - M_AXIS_TVALID = (count!=0) & RES_TVALID[head.lane].
  - M_AXIS_TDATA = RES_TDATA slice head.lane.
  - M_AXIS_TID = head.tid.
  - RES_TREADY[k] = M_AXIS_TREADY & (count!=0) & (head.lane==k).
- On M_AXIS handshake: pop the FIFO and clear busy[head.lane] at the next edge.
- A lane's result is never consumed out of order. A valid result on a non-head lane is held (RES_TREADY=0) until that lane reaches the head.
- Simultaneous events:
  - Push and pop in the same cycle leave count unchanged; IN_FLIGHT = count.
  - If the lane being retired equals disp_lane in that cycle, dispatch stalls that cycle (busy still 1). The lane is dispatchable on the next cycle.
- All lanes busy: S_AXIS_TREADY=0 until the head retires.
- Throughput: one beat per cycle while the target lane is free and ready; one result per cycle at the output.

Test Plan:
- Reset, then 4 single-beat packets {in=2, w=3}, TIDs 10..13, with a lane-model MAC (result = Σ in·w) → lanes 0,1,2,3 each receive one beat with LANE_TLAST=1; outputs 6,6,6,6 with TIDs 10,11,12,13 in order; IN_FLIGHT peaks at 4.
- 5th packet sent while all lanes busy and M_AXIS_TREADY=0 → S_AXIS_TREADY=0 and LANE_BUSY=4'b1111. Raising M_AXIS_TREADY retires TID 10 first; the 5th packet then dispatches to lane 0 one cycle after lane 0 retires.
- Lane 2 result valid before lane 1 (lane model delays lane 1 by 5 cycles) → RES_TREADY[2]=0 until lane 1's result is consumed; output order is still TID 11 then 12.
- 3-beat packet {1,1},{2,2},{3,3} with TID 0x55 → all three beats go to one lane, disp_lane advances only after the TLAST beat; output 14 with TID 0x55.
- ARESET asserted with 2 packets in flight and the 3rd packet mid-stream → next cycle IN_FLIGHT=0 and LANE_BUSY=0; no result beat is emitted for discarded packets; the next packet dispatches to lane 0.
- Backpressure from the target lane (LANE_TREADY[1]=0 for 3 cycles while disp_lane=1) → S_AXIS_TREADY=0 for exactly those 3 cycles; no beat is lost or duplicated.
